// File: rtl/flash_arb_pkg.sv
// -----------------------------------------------------------------------------
// flash_arb_pkg
// Shared types and constants for the Flash port arbiter.
//   arb_state_t   : arbiter FSM states (IDLE/ISSUE/WAIT/DONE)
//   PORT_UART/DISP: requester port ids
//   FL_DIR_*      : Flash engine direction encoding
//   rr_pick       : round-robin winner selection for two requesters
// -----------------------------------------------------------------------------
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic PORT_UART    = 1'b0;
   localparam logic PORT_DISP    = 1'b1;

   localparam logic FL_DIR_READ  = 1'b0;
   localparam logic FL_DIR_WRITE = 1'b1;

   // A lone requester always wins; under contention the preferred port wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic pref);
      return (req == 2'b11) ? pref : req[1];
   endfunction

endpackage

// File: rtl/flash_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// flash_port_arbiter_if
// Bundles the two requester ports and the Flash engine port of the arbiter.
//   req/rw/addr0/addr1/wdata0/wdata1 : requester side, driven by the ports
//   ack/err/rdata                    : completion returned to the ports
//   fl_trg/fl_flow/fl_addr/fl_wdata  : command to the Flash byte engine
//   fl_rdata/fl_status               : read data and done from the engine
// Modports: slave = the arbiter, master = the requesters plus Flash engine.
// -----------------------------------------------------------------------------
interface flash_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic [1:0]    req;
   logic [1:0]    rw;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic [1:0]    ack;
   logic [1:0]    err;
   logic [DW-1:0] rdata;
   logic          fl_trg;
   logic          fl_flow;
   logic [AW-1:0] fl_addr;
   logic [DW-1:0] fl_wdata;
   logic [DW-1:0] fl_rdata;
   logic          fl_status;

   modport slave (
      input  req, rw, addr0, addr1, wdata0, wdata1, fl_rdata, fl_status,
      output ack, err, rdata, fl_trg, fl_flow, fl_addr, fl_wdata
   );

   modport master (
      output req, rw, addr0, addr1, wdata0, wdata1, fl_rdata, fl_status,
      input  ack, err, rdata, fl_trg, fl_flow, fl_addr, fl_wdata
   );
endinterface

// File: rtl/flash_port_arbiter.sv
// -----------------------------------------------------------------------------
// flash_port_arbiter
// Shares one Flash byte-access engine between port 0 (UART command manager)
// and port 1 (scoreboard display refresh reader). Round-robin grant, a single
// transaction in flight: latch the winner's command, pulse fl_trg, wait for
// fl_status, return read data with a one-cycle ack to the granted port.
//
// Ports:
//   CLK_50MHZ : system clock, rising edge
//   RST_N     : asynchronous active-low reset
//   bus       : flash_port_arbiter_if.slave (requester + Flash engine signals)
//
// Build option:
//   FLARB_TIMEOUT_EN : abort a WAIT lasting TIMEOUT_CYC cycles with err set
//                      on the granted port; undefined -> WAIT holds forever and
//                      err is tied low.
// -----------------------------------------------------------------------------
module flash_port_arbiter
   import flash_arb_pkg::*;
#(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                   CLK_50MHZ,
   input  logic                   RST_N,
   flash_port_arbiter_if.slave    bus
);

   arb_state_t    state;
   logic          grant;      // port owning the transaction in flight
   logic          rr_pref;    // port that wins when both request
   logic          win;
   logic          trg_q;
   logic          flow_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [1:0]    ack_q;

   always_comb win = rr_pick(bus.req, rr_pref);

`ifdef FLARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] tmo_cnt;
   logic [1:0]    err_q;
   logic          tmo_hit;

   // Expires on the TIMEOUT_CYC-th WAIT cycle without done.
   always_comb tmo_hit = (tmo_cnt == TMO_LAST);

   assign bus.err = err_q;
`else
   assign bus.err = '0;
`endif

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would chain updates in order.
   always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         grant   <= PORT_UART;
         rr_pref <= PORT_UART;
         trg_q   <= 1'b0;
         flow_q  <= FL_DIR_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
`ifdef FLARB_TIMEOUT_EN
         tmo_cnt <= '0;
         err_q   <= '0;
`endif
      end else begin
         // NOTE: pulse outputs default low each cycle and are raised only in
         // the one transition that owns them, giving exact one-cycle pulses.
         trg_q <= 1'b0;
         ack_q <= '0;
`ifdef FLARB_TIMEOUT_EN
         err_q <= '0;
`endif
         unique case (state)
            IDLE: begin
               if (|bus.req) begin
                  grant   <= win;
                  flow_q  <= bus.rw[win];
                  addr_q  <= (win == PORT_DISP) ? bus.addr1  : bus.addr0;
                  wdata_q <= (win == PORT_DISP) ? bus.wdata1 : bus.wdata0;
                  trg_q   <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               // A level done still high from earlier is ignored here.
               state <= WAIT;
`ifdef FLARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
               // Done beats a timeout expiring in the same cycle.
               if (bus.fl_status) begin
                  if (flow_q == FL_DIR_READ) rdata_q <= bus.fl_rdata;
                  ack_q[grant] <= 1'b1;
                  state        <= DONE;
               end
`ifdef FLARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  ack_q[grant] <= 1'b1;
                  err_q[grant] <= 1'b1;
                  state        <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               rr_pref <= ~grant;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rdata    = rdata_q;
   assign bus.fl_trg   = trg_q;
   assign bus.fl_flow  = flow_q;
   assign bus.fl_addr  = addr_q;
   assign bus.fl_wdata = wdata_q;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_port_arbiter
// Scoreboarded bench for flash_port_arbiter. A Flash engine model answers each
// fl_trg; at that moment a reference arbiter (last-granted-port rule) decides
// which port should own the command and pushes the expected ack into a queue.
// A monitor pops that queue whenever the DUT raises ack.
// Honours FLARB_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_flash_port_arbiter;
   import flash_arb_pkg::*;

   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   flash_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   flash_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
      .CLK_50MHZ (clk),
      .RST_N     (rst_n),
      .bus       (bus)
   );

   typedef struct {
      int            port;
      logic          err;
      logic [DW-1:0] rdata;
      int            ack_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   grant_log[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   logic [1:0]    req_prev = '0;
   int            last_m   = 1;      // so port 0 wins the first contention
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rdata_m  = '0;

   // Flash engine model state
   bit            fm_busy     = 0;
   bit            fm_level    = 0;
   bit            fm_never    = 0;
   bit            fm_pulse_clr = 0;
   int            fm_cnt      = 0;
   int            fm_delay    = -1;
   logic          fm_flow;
   logic [AW-1:0] fm_addr;
   logic [DW-1:0] fm_wdata;
   int            trg_count   = 0;
   int            exp_trg_cyc = -1;

   // port traffic state
   int  done_cnt [2] = '{0, 0};
   int  pend     [2] = '{0, 0};
   int  gap      [2] = '{0, 0};
   bit  gap_rand = 0;

   int            m_g, m_k;
   logic          m_r;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_w;
   logic [1:0]    m_err_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.rw[p] = rw;
      if (p == 0) begin
         bus.addr0  = a;
         bus.wdata0 = d;
      end else begin
         bus.addr1  = a;
         bus.wdata1 = d;
      end
      bus.req[p] = 1'b1;
   endtask

   task automatic issue_rand(input int p);
      issue(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
   endtask

   task automatic wait_done(input int p, input int target, input int budget);
      int n = 0;
      while (done_cnt[p] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check($sformatf("wait_done_p%0d", p), 32'(done_cnt[p] >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_ack",      bus.ack,      '0);
      check("rst_err",      bus.err,      '0);
      check("rst_rdata",    bus.rdata,    '0);
      check("rst_fl_trg",   bus.fl_trg,   '0);
      check("rst_fl_flow",  bus.fl_flow,  '0);
      check("rst_fl_addr",  bus.fl_addr,  '0);
      check("rst_fl_wdata", bus.fl_wdata, '0);
      sb.delete();
      bus.req       = '0;
      bus.fl_status = 1'b0;
      fm_busy       = 0;
      fm_cnt        = 0;
      fm_pulse_clr  = 0;
      pend          = '{0, 0};
      gap           = '{0, 0};
      last_m        = 1;
      rdata_m       = '0;
      exp_trg_cyc   = -1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      cyc++;
      req_prev = bus.req;
   end

   // Monitor, scoreboard consumer, Flash engine model and port re-requests.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ack != 2'b00) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
               e = sb.pop_front();
               m_err_exp = e.err ? (2'b01 << e.port) : 2'b00;
               check("ack_port",  32'(bus.ack), 32'(2'b01 << e.port));
               check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
               check("ack_err",   32'(bus.err), 32'(m_err_exp));
               check("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
               done_cnt[e.port]++;
               bus.req[e.port] = 1'b0;
               fm_busy = 0;
               if (fm_level) bus.fl_status = 1'b0;
               gap[e.port] = gap_rand ? int'($urandom_range(0, 6)) : 0;
            end
         end

         if (fm_pulse_clr) begin
            bus.fl_status = 1'b0;
            fm_pulse_clr  = 0;
         end

         if (bus.fl_trg) begin
            trg_count++;
            check("trg_while_busy", 32'(fm_busy), 32'd0);
            if (exp_trg_cyc >= 0) begin
               check("trg_latency", 32'(cyc), 32'(exp_trg_cyc));
               exp_trg_cyc = -1;
            end
            check("trg_has_req", 32'(req_prev != 2'b00), 32'd1);
            m_g = (req_prev == 2'b11) ? 1 - last_m : (req_prev[1] ? 1 : 0);
            last_m = m_g;
            grant_log.push_back(m_g);
            m_a = (m_g == 1) ? bus.addr1  : bus.addr0;
            m_w = (m_g == 1) ? bus.wdata1 : bus.wdata0;
            m_r = bus.rw[m_g];
            check("fl_flow",  32'(bus.fl_flow),  32'(m_r));
            check("fl_addr",  32'(bus.fl_addr),  32'(m_a));
            check("fl_wdata", 32'(bus.fl_wdata), 32'(m_w));
            fm_flow  = m_r;
            fm_addr  = m_a;
            fm_wdata = m_w;
            fm_busy  = 1;
            m_k      = fm_level ? 1 : (fm_delay >= 0 ? fm_delay : int'($urandom_range(1, 6)));
            fm_cnt   = m_k;
            if (fm_never) begin
`ifdef FLARB_TIMEOUT_EN
               sb.push_back('{port: m_g, err: 1'b1, rdata: rdata_m, ack_cyc: cyc + 1 + TMO});
`endif
            end else begin
               if (m_r == FL_DIR_READ) begin
                  bus.fl_rdata = mem[m_a];
                  rdata_m      = mem[m_a];
               end else begin
                  mem[m_a]     = m_w;
                  bus.fl_rdata = DW'($urandom);
               end
               sb.push_back('{port: m_g, err: 1'b0, rdata: rdata_m, ack_cyc: cyc + m_k + 1});
            end
         end else if (fm_busy) begin
            check("fl_flow_stable",  32'(bus.fl_flow),  32'(fm_flow));
            check("fl_addr_stable",  32'(bus.fl_addr),  32'(fm_addr));
            check("fl_wdata_stable", 32'(bus.fl_wdata), 32'(fm_wdata));
            if (!fm_never && fm_cnt > 0) begin
               fm_cnt--;
               if (fm_cnt == 0) begin
                  bus.fl_status = 1'b1;
                  if (!fm_level) fm_pulse_clr = 1;
               end
            end
         end

         for (int p = 0; p < 2; p++) begin
            if (!bus.req[p] && pend[p] > 0) begin
               if (gap[p] > 0) gap[p]--;
               else begin
                  issue_rand(p);
                  pend[p]--;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, b1, n0;
      bus.req = '0; bus.rw = '0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus.fl_rdata = '0; bus.fl_status = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = DW'(i * 7 + 1);
      mem[8'h12] = 8'hA5;
      #2;
      do_reset();

      // 1: port 0 read, done after 5 cycles
      @(posedge clk); #2;
      fm_delay    = 5;
      exp_trg_cyc = cyc + 1;
      issue(0, FL_DIR_READ, 8'h12, 8'h00);
      wait_done(0, 1, 50);

      // 2: port 1 write; RDATA must keep 0xA5
      @(posedge clk); #2;
      fm_delay = 2;
      issue(1, FL_DIR_WRITE, 8'h40, 8'h3C);
      wait_done(1, 1, 50);

      // 6: level done already high through ISSUE
      @(posedge clk); #2;
      fm_level      = 1;
      bus.fl_status = 1'b1;
      issue(0, FL_DIR_READ, 8'h40, 8'h00);
      wait_done(0, 2, 50);
      fm_level = 0;

      // 3: continuous contention from reset -> strict alternation
      do_reset();
      fm_delay = -1;
      grant_log.delete();
      b0 = done_cnt[0]; b1 = done_cnt[1];
      @(posedge clk); #2;
      issue_rand(0);
      issue_rand(1);
      pend = '{2, 2};
      wait_done(0, b0 + 3, 200);
      wait_done(1, b1 + 3, 200);
      for (int i = 0; i < 6; i++)
         check($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

      // random traffic with random gaps and done delays
      gap_rand = 1;
      b0 = done_cnt[0]; b1 = done_cnt[1];
      pend = '{25, 25};
      wait_done(0, b0 + 25, 4000);
      wait_done(1, b1 + 25, 4000);
      gap_rand = 0;

      // 4: Flash never answers
      @(posedge clk); #2;
      fm_never = 1;
      b1 = done_cnt[1];
      n0 = trg_count;
      issue(1, FL_DIR_READ, 8'h07, 8'h00);
`ifdef FLARB_TIMEOUT_EN
      wait_done(1, b1 + 1, TMO + 20);
      fm_never = 0;
      fm_delay = 3;
      b0 = done_cnt[0];
      @(posedge clk); #2;
      issue(0, FL_DIR_READ, 8'h12, 8'h00);
      wait_done(0, b0 + 1, 50);
      // 5 setup: a fresh transaction parked in WAIT
      fm_never = 1;
      @(posedge clk); #2;
      issue(0, FL_DIR_READ, 8'h21, 8'h00);
      repeat (5) @(posedge clk);
      #2;
`else
      repeat (40) @(posedge clk);
      check("stuck_no_ack", 32'(done_cnt[1]), 32'(b1));
      check("stuck_one_trg", 32'(trg_count), 32'(n0 + 1));
      #2;
`endif

      // 5: reset while in WAIT, then port 0 wins a simultaneous request
      do_reset();
      fm_never = 0;
      fm_delay = -1;
      n0 = grant_log.size();
      b0 = done_cnt[0]; b1 = done_cnt[1];
      @(posedge clk); #2;
      issue_rand(0);
      issue_rand(1);
      wait_done(0, b0 + 1, 100);
      wait_done(1, b1 + 1, 100);
      check("post_reset_first_grant", 32'(grant_log[n0]), 32'd0);

      repeat (5) @(posedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
